ssd_scan_decoder: RTL and testbench

- Receive-side counterpart of the BCD-to-segment encoder: samples a multiplexed seven-segment bus (digit select plus segments) and recovers the displayed BCD digits.
- Used for display readback and self-check: the score/readout driver output is looped back and compared against the intended value.
- Accepts each digit only after its pattern has been stable for a programmable number of cycles.
- Assembles a full frame, then presents it on a valid/ready output.

---
 rtl/ssd_scan_decoder_pkg.sv | 31 +++
 rtl/ssd_scan_decoder_if.sv | 33 +++
 rtl/ssd_pattern_decode.sv | 42 ++++
 rtl/ssd_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared constants for the seven-segment scan decoder: segment patterns
// (bit0=a .. bit6=g, active-high), the special nibble codes for blank and
// undecodable digits, and the frame-assembly FSM state type.
// ---------------------------------------------------------------------------
package ssd_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_ERR   = 4'hE;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } scanState_t;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_decoder_if
// Bundles the looped-back display bus (an, seg), the decoded frame outputs
// and the valid/ready/overrun handshake of the scan decoder.
//   master : the side driving the display bus and consuming frames
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface ssd_scan_decoder_if #(
   parameter int DIGITS = 4
);
   import ssd_pkg::*;

   logic [DIGITS-1:0]   an;
   logic [SEG_W-1:0]    seg;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank_out;
   logic [DIGITS-1:0]   err_out;
   logic                valid;
   logic                ready;
   logic                overrun;
   logic                overrun_clr;

   modport master (
      output an, seg, ready, overrun_clr,
      input  bcd_out, blank_out, err_out, valid, overrun
   );

   modport slave (
      input  an, seg, ready, overrun_clr,
      output bcd_out, blank_out, err_out, valid, overrun
   );

endinterface

// File: rtl/ssd_pattern_decode.sv
// ---------------------------------------------------------------------------
// ssd_pattern_decode
// Combinational inverse of the BCD-to-segment encoder table.
//   i_seg    : segment pattern, bit0=a .. bit6=g, active-high
//   o_nibble : 0..9 on a table match, BCD_BLANK when all-off, else BCD_ERR
//   o_blank  : pattern was all-off
//   o_err    : pattern is neither a digit nor blank
// ---------------------------------------------------------------------------
module ssd_pattern_decode
   import ssd_pkg::*;
(
   input  logic [SEG_W-1:0] i_seg,
   output logic [3:0]       o_nibble,
   output logic             o_blank,
   output logic             o_err
);

   // Straight table lookup; anything unrecognised falls to the error code.
   always_comb begin
      o_nibble = BCD_ERR;
      o_blank  = 1'b0;
      o_err    = 1'b0;
      case (i_seg)
         SEG_0:     o_nibble = 4'd0;
         SEG_1:     o_nibble = 4'd1;
         SEG_2:     o_nibble = 4'd2;
         SEG_3:     o_nibble = 4'd3;
         SEG_4:     o_nibble = 4'd4;
         SEG_5:     o_nibble = 4'd5;
         SEG_6:     o_nibble = 4'd6;
         SEG_7:     o_nibble = 4'd7;
         SEG_8:     o_nibble = 4'd8;
         SEG_9:     o_nibble = 4'd9;
         SEG_BLANK: begin
            o_nibble = BCD_BLANK;
            o_blank  = 1'b1;
         end
         default:   o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ---------------------------------------------------------------------------
// ssd_scan_decoder
// Samples a multiplexed seven-segment bus, accepts each digit once its
// {select, segments} pattern has been stable for STABLE_CYCLES cycles,
// assembles a full frame of DIGITS digits and presents it on valid/ready.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : ssd_scan_decoder_if.slave (an, seg, ready, overrun_clr in;
//          bcd_out, blank_out, err_out, valid, overrun out)
// Build option: SSD_SCAN_DECODER_ACTIVE_LOW_EN inverts an and seg at the
// input register for common-anode hardware.
// ---------------------------------------------------------------------------
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic                clk,
   input  logic                rst,
   ssd_scan_decoder_if.slave   bus
);

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

   logic [DIGITS-1:0]       r_anQ;
   logic [SEG_W-1:0]        r_segQ;
   logic [DIGITS+SEG_W-1:0] r_prevSample;
   logic [CNT_W-1:0]        r_cnt;
   logic [DIGITS-1:0]       r_mask;
   logic [4*DIGITS-1:0]     r_shBcd;
   logic [DIGITS-1:0]       r_shBlank;
   logic [DIGITS-1:0]       r_shErr;
   logic [4*DIGITS-1:0]     r_bcdOut;
   logic [DIGITS-1:0]       r_blankOut;
   logic [DIGITS-1:0]       r_errOut;
   logic                    r_overrun;
   scanState_t              r_state;

   logic [DIGITS+SEG_W-1:0] w_sample;
   logic                    w_oneHot;
   logic [CNT_W-1:0]        w_cntNext;
   logic                    w_capture;
   logic [3:0]              w_nibble;
   logic                    w_blank;
   logic                    w_err;
   logic [DIGITS-1:0]       w_maskMerged;
   logic [4*DIGITS-1:0]     w_shBcd;
   logic [DIGITS-1:0]       w_shBlank;
   logic [DIGITS-1:0]       w_shErr;
   logic                    w_frameDone;
   scanState_t              w_stateNext;
   logic                    w_loadOut;
   logic                    w_setOverrun;
   logic [DIGITS-1:0]       w_maskNext;

   // Single input register stage; everything downstream works on these
   // copies. The common-anode build inverts here so the rest is unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_anQ  <= '0;
         r_segQ <= '0;
      end else begin
`ifdef SSD_SCAN_DECODER_ACTIVE_LOW_EN
         r_anQ  <= ~bus.an;
         r_segQ <= ~bus.seg;
`else
         r_anQ  <= bus.an;
         r_segQ <= bus.seg;
`endif
      end
   end

   assign w_sample = {r_anQ, r_segQ};
   assign w_oneHot = $onehot(r_anQ);

   // Stability counter: counts consecutive identical one-hot samples and
   // parks at STABLE_MAX so a long run captures only once. A new one-hot
   // sample starts a fresh run at 1; an idle or ghosted select holds it at 0.
   always_comb begin
      w_cntNext = '0;
      if (w_oneHot && (w_sample == r_prevSample)) begin
         w_cntNext = (r_cnt == STABLE_MAX) ? STABLE_MAX : r_cnt + CNT_W'(1);
      end else if (w_oneHot) begin
         w_cntNext = CNT_W'(1);
      end
   end

   assign w_capture = (w_cntNext == STABLE_MAX) && (r_cnt != STABLE_MAX);

   ssd_pattern_decode u_decode (
      .i_seg    (r_segQ),
      .o_nibble (w_nibble),
      .o_blank  (w_blank),
      .o_err    (w_err)
   );

   // Shadow frame as it will look after this cycle's capture (if any), so a
   // completing digit can go straight to the outputs on the same edge.
   always_comb begin
      w_maskMerged = r_mask;
      w_shBcd      = r_shBcd;
      w_shBlank    = r_shBlank;
      w_shErr      = r_shErr;
      if (w_capture) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (r_anQ[i]) begin
               w_shBcd[4*i +: 4] = w_nibble;
               w_shBlank[i]      = w_blank;
               w_shErr[i]        = w_err;
               w_maskMerged[i]   = 1'b1;
            end
         end
      end
   end

   assign w_frameDone = w_capture && (&w_maskMerged);

   // FSM next-state: COLLECT publishes a completed frame and moves to HOLD.
   // In HOLD a completed frame either replaces the one being handed off
   // (ready this cycle) or is dropped and flagged as overrun.
   always_comb begin
      w_stateNext  = r_state;
      w_loadOut    = 1'b0;
      w_setOverrun = 1'b0;
      w_maskNext   = w_maskMerged;
      case (r_state)
         COLLECT: begin
            if (w_frameDone) begin
               w_loadOut   = 1'b1;
               w_maskNext  = '0;
               w_stateNext = HOLD;
            end
         end
         HOLD: begin
            if (w_frameDone) begin
               w_maskNext = '0;
               if (bus.ready) begin
                  w_loadOut = 1'b1;
               end else begin
                  w_setOverrun = 1'b1;
               end
            end else if (bus.ready) begin
               w_stateNext = COLLECT;
            end
         end
         default: w_stateNext = COLLECT;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Stability tracking, shadow frame and published frame registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prevSample <= '0;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_shBcd      <= '0;
         r_shBlank    <= '0;
         r_shErr      <= '0;
         r_bcdOut     <= '0;
         r_blankOut   <= '0;
         r_errOut     <= '0;
      end else begin
         r_prevSample <= w_sample;
         r_cnt        <= w_cntNext;
         r_mask       <= w_maskNext;
         r_shBcd      <= w_shBcd;
         r_shBlank    <= w_shBlank;
         r_shErr      <= w_shErr;
         if (w_loadOut) begin
            r_bcdOut   <= w_shBcd;
            r_blankOut <= w_shBlank;
            r_errOut   <= w_shErr;
         end
      end
   end

   // Sticky overrun flag; a new drop in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_setOverrun) begin
         r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign bus.bcd_out   = r_bcdOut;
   assign bus.blank_out = r_blankOut;
   assign bus.err_out   = r_errOut;
   assign bus.valid     = (r_state == HOLD);
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_decoder
// Self-checking bench for ssd_scan_decoder with DIGITS=4, STABLE_CYCLES=4.
// Expected frames go into a scoreboard queue as each scan is driven and are
// popped and compared whenever the decoder hands a frame over.
// ---------------------------------------------------------------------------
module tb_ssd_scan_decoder;

   localparam int DIGITS = 4;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
   } frame_t;

   logic   clk;
   logic   rst;
   int     checkCount;
   int     errorCount;
   int     hsCount;
   int     expHs;
   frame_t sb[$];

   ssd_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

   ssd_scan_decoder #(
      .DIGITS        (DIGITS),
      .STABLE_CYCLES (4),
      .CNT_W         (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Encoder table written out independently of the RTL package.
   function automatic logic [6:0] segOf(input int d);
      case (d)
         0: segOf = 7'b0111111;
         1: segOf = 7'b0000110;
         2: segOf = 7'b1011011;
         3: segOf = 7'b1001111;
         4: segOf = 7'b1100110;
         5: segOf = 7'b1101101;
         6: segOf = 7'b1111101;
         7: segOf = 7'b0000111;
         8: segOf = 7'b1111111;
         9: segOf = 7'b1101111;
         default: segOf = 7'b0000000;
      endcase
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock: watch for a handshake at the falling edge, then step to
   // just after the next rising edge where new inputs get applied.
   task automatic cycle();
      frame_t f;
      @(negedge clk);
      if (!rst && bus.valid && bus.ready) begin
         hsCount++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
         end else begin
            f = sb.pop_front();
            checkOutput("frame_bcd",   {16'd0, bus.bcd_out},   {16'd0, f.bcd});
            checkOutput("frame_blank", {28'd0, bus.blank_out}, {28'd0, f.blank});
            checkOutput("frame_err",   {28'd0, bus.err_out},   {28'd0, f.err});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.an  = '0;
      bus.seg = '0;
      repeat (n) cycle();
   endtask

   task automatic scanDigit(input int idx, input logic [6:0] pattern, input int hold);
      bus.an  = 4'(1 << idx);
      bus.seg = pattern;
      repeat (hold) cycle();
   endtask

   task automatic applyStimulus(input logic [6:0] p0, input logic [6:0] p1,
                                input logic [6:0] p2, input logic [6:0] p3,
                                input int hold);
      scanDigit(0, p0, hold);
      scanDigit(1, p1, hold);
      scanDigit(2, p2, hold);
      scanDigit(3, p3, hold);
      bus.an  = '0;
      bus.seg = '0;
   endtask

   task automatic pushFrame(input logic [15:0] bcd, input logic [3:0] blank,
                            input logic [3:0] err);
      frame_t f;
      f.bcd   = bcd;
      f.blank = blank;
      f.err   = err;
      sb.push_back(f);
      expHs++;
   endtask

   // Idle until the scoreboard empties, bounded by a cycle budget.
   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      bus.an  = '0;
      bus.seg = '0;
      while (sb.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      if (sb.size() != 0) begin
         checkOutput("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      checkCount      = 0;
      errorCount      = 0;
      hsCount         = 0;
      expHs           = 0;
      rst             = 1'b1;
      bus.an          = '0;
      bus.seg         = '0;
      bus.ready       = 1'b1;
      bus.overrun_clr = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) cycle();

      $display("[TB] reset state");
      checkOutput("rst_bcd",     {16'd0, bus.bcd_out},   32'd0);
      checkOutput("rst_blank",   {28'd0, bus.blank_out}, 32'd0);
      checkOutput("rst_err",     {28'd0, bus.err_out},   32'd0);
      checkOutput("rst_valid",   {31'd0, bus.valid},     32'd0);
      checkOutput("rst_overrun", {31'd0, bus.overrun},   32'd0);
      rst = 1'b0;
      idle(2);

      $display("[TB] basic frame 4321");
      pushFrame(16'h4321, 4'b0000, 4'b0000);
      applyStimulus(segOf(1), segOf(2), segOf(3), segOf(4), 6);
      waitDrain(40);
      idle(5);
      checkOutput("basic_hs_count", hsCount, expHs);
      checkOutput("basic_valid_low", {31'd0, bus.valid}, 32'd0);

      $display("[TB] short hold, no capture");
      applyStimulus(segOf(5), segOf(6), segOf(7), segOf(8), 3);
      idle(20);
      checkOutput("short_hs_count", hsCount, expHs);
      checkOutput("short_valid", {31'd0, bus.valid}, 32'd0);

      $display("[TB] blank and error digits");
      pushFrame(16'h9FE7, 4'b0100, 4'b0010);
      applyStimulus(segOf(7), 7'b1010101, 7'b0000000, segOf(9), 6);
      waitDrain(40);
      idle(5);
      checkOutput("blankerr_hs_count", hsCount, expHs);

      $display("[TB] overrun with ready low");
      bus.ready = 1'b0;
      pushFrame(16'h1890, 4'b0000, 4'b0000);
      applyStimulus(segOf(0), segOf(9), segOf(8), segOf(1), 6);
      applyStimulus(segOf(2), segOf(4), segOf(6), segOf(8), 6);
      idle(4);
      checkOutput("ovr_valid",   {31'd0, bus.valid},   32'd1);
      checkOutput("ovr_bcd_held", {16'd0, bus.bcd_out}, 32'h1890);
      checkOutput("ovr_flag",    {31'd0, bus.overrun}, 32'd1);
      bus.overrun_clr = 1'b1;
      cycle();
      bus.overrun_clr = 1'b0;
      checkOutput("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
      bus.ready = 1'b1;
      waitDrain(10);
      idle(3);
      checkOutput("ovr_hs_count", hsCount, expHs);
      checkOutput("ovr_valid_low", {31'd0, bus.valid}, 32'd0);

      $display("[TB] multi-hot select ignored");
      bus.an  = 4'b0011;
      bus.seg = segOf(3);
      repeat (20) cycle();
      scanDigit(2, segOf(4), 6);
      scanDigit(3, segOf(1), 6);
      idle(10);
      checkOutput("multihot_no_frame", hsCount, expHs);
      pushFrame(16'h1413, 4'b0000, 4'b0000);
      scanDigit(0, segOf(3), 6);
      scanDigit(1, segOf(1), 6);
      waitDrain(40);
      idle(3);
      checkOutput("multihot_hs_count", hsCount, expHs);

      $display("[TB] reset mid-frame, minimum hold");
      scanDigit(0, segOf(9), 6);
      scanDigit(1, segOf(9), 6);
      rst     = 1'b1;
      bus.an  = '0;
      bus.seg = '0;
      cycle();
      rst = 1'b0;
      checkOutput("midrst_valid", {31'd0, bus.valid}, 32'd0);
      scanDigit(2, segOf(7), 4);
      scanDigit(3, segOf(8), 4);
      idle(10);
      checkOutput("midrst_no_frame", hsCount, expHs);
      pushFrame(16'h8765, 4'b0000, 4'b0000);
      scanDigit(0, segOf(5), 4);
      scanDigit(1, segOf(6), 4);
      waitDrain(40);
      idle(3);
      checkOutput("midrst_hs_count", hsCount, expHs);

      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
